// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared execute-pipeline definitions.
//   fwd_sel_t : select encoding for the Exec operand muxes (mux3).
//   PC_IDX    : register index of the PC; never forwarded.
//   e_tags_t  : register tags carried by the D/E stage of the hazard unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from the register file (Rd1E/Rd2E)
    FWD_WB  = 2'b01,  // operand from ResultW
    FWD_MEM = 2'b10   // operand from ALUResultM
  } fwd_sel_t;

  localparam logic [3:0] PC_IDX = 4'd15;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       use_a;
    logic       use_b;
    logic [3:0] rd;
    logic       mem;    // instruction in E is a load
    logic       multi;  // instruction in E is a multi-cycle ALU op
  } e_tags_t;

endpackage

// File: rtl/exec_hazard_ctrl_if.sv
// exec_hazard_ctrl_if -- bundle between the execute pipeline and its hazard unit.
//   Decode side : RA1D, RA2D, UseA_D, UseB_D, RdD, RegWriteD, MemtoRegD, MultiCycleD
//   Exec side   : RegWriteE (condition-qualified), PCSrcE (taken branch in E)
//   Hazard side : forwardAE/forwardBE, StallF/D/E, FlushD/E/M, BusyE
// master = pipeline (drives instruction info), slave = hazard controller.
interface exec_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [3:0] RA1D;
  logic [3:0] RA2D;
  logic       UseA_D;
  logic       UseB_D;
  logic [3:0] RdD;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       MultiCycleD;
  logic       RegWriteE;
  logic       PCSrcE;

  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       BusyE;

  modport master (
    output RA1D, RA2D, UseA_D, UseB_D, RdD, RegWriteD, MemtoRegD, MultiCycleD,
           RegWriteE, PCSrcE,
    input  forwardAE, forwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
           BusyE
  );

  modport slave (
    input  RA1D, RA2D, UseA_D, UseB_D, RdD, RegWriteD, MemtoRegD, MultiCycleD,
           RegWriteE, PCSrcE,
    output forwardAE, forwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
           BusyE
  );

endinterface

// File: rtl/exec_hazard_ctrl_mc_counter.sv
// mc_counter -- occupancy counter for multi-cycle ALU ops in E.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : a multi-cycle op enters E on this edge
//   multi_e_i   : the op currently held in E is multi-cycle
//   busy_o      : remaining occupancy non-zero (E must be held)
// A MUL_LAT-cycle op needs MUL_LAT-1 extra cycles in E, so the counter loads
// MUL_LAT-1; MUL_LAT=1 therefore never raises busy_o.
module mc_counter #(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic multi_e_i,
  output logic busy_o
);

  localparam logic [3:0] LOAD_VAL = 4'(MUL_LAT - 1);

  logic [3:0] cnt_q, cnt_d;

  // A non-zero count always belongs to the multi-cycle op frozen in E, so
  // gating the decrement with multi_e_i only documents that pairing.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if ((cnt_q != 4'd0) && multi_e_i) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/exec_hazard_ctrl.sv
// exec_hazard_ctrl -- hazard/forwarding scheduler for the execute datapath.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : exec_hazard_ctrl_if.slave
//            in : decode tags (RA1D, RA2D, UseA_D, UseB_D, RdD, RegWriteD,
//                 MemtoRegD, MultiCycleD), RegWriteE, PCSrcE
//            out: forwardAE/forwardBE, StallF/D/E, FlushD/E/M, BusyE
// Keeps a shadow copy of the E/M/W register tags that advances, holds and
// bubbles exactly as the stall/flush signals it issues to the real pipeline.
module exec_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int         MUL_LAT = 3,
  parameter logic [3:0] PC_REG  = PC_IDX
) (
  input  logic                clk,
  input  logic                reset,
  exec_hazard_ctrl_if.slave   bus
);

  e_tags_t    e_q, e_d;
  logic [3:0] rd_m_q, rd_m_d;
  logic       rw_m_q, rw_m_d;
  logic [3:0] rd_w_q;
  logic       rw_w_q;
  logic       ready_q;

  fwd_sel_t   fwd_a, fwd_b;
  logic       ldstall;
  logic       pcsrc;
  logic       busy;
  logic       stall_f;
  logic       flush_e;
  logic       enter_e;

  // Forwarding: the M stage holds the younger result, so it wins over W.
  always_comb begin
    fwd_a = FWD_RF;
    if (e_q.use_a && (e_q.ra1 != PC_REG)) begin
      if (rw_m_q && (rd_m_q == e_q.ra1)) begin
        fwd_a = FWD_MEM;
      end else if (rw_w_q && (rd_w_q == e_q.ra1)) begin
        fwd_a = FWD_WB;
      end
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (e_q.use_b && (e_q.ra2 != PC_REG)) begin
      if (rw_m_q && (rd_m_q == e_q.ra2)) begin
        fwd_b = FWD_MEM;
      end else if (rw_w_q && (rd_w_q == e_q.ra2)) begin
        fwd_b = FWD_WB;
      end
    end
  end

  assign ldstall = e_q.mem & ((bus.UseA_D & (bus.RA1D == e_q.rd)) |
                              (bus.UseB_D & (bus.RA2D == e_q.rd)));

  // The first cycle out of reset ignores PCSrcE so every output stays quiet
  // until the surrounding pipeline registers have been clocked once.
  assign pcsrc = bus.PCSrcE & ready_q;

  // A taken branch must let F load the target, so it cancels any stall.
  // While a MUL is busy the load cannot be in E, so ldstall is stale and is
  // kept out of FlushE (it still holds F/D, which StallE requires anyway).
  assign stall_f = (ldstall | busy) & ~pcsrc;
  assign flush_e = (ldstall & ~busy) | pcsrc;
  assign enter_e = ~busy & ~flush_e;

  mc_counter #(
    .MUL_LAT (MUL_LAT)
  ) u_mc_counter (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (enter_e & bus.MultiCycleD),
    .multi_e_i (e_q.multi),
    .busy_o    (busy)
  );

  // D->E and E->M tag next-state
  always_comb begin
    e_d = e_q;
    if (!busy) begin
      if (flush_e) begin
        e_d = '0;
      end else begin
        e_d.ra1   = bus.RA1D;
        e_d.ra2   = bus.RA2D;
        e_d.use_a = bus.UseA_D;
        e_d.use_b = bus.UseB_D;
        e_d.rd    = bus.RdD;
        e_d.mem   = bus.MemtoRegD;
        e_d.multi = bus.MultiCycleD;
      end
    end

    rd_m_d = e_q.rd;
    rw_m_d = bus.RegWriteE;
    if (busy) begin
      rd_m_d = 4'd0;
      rw_m_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q     <= '0;
      rd_m_q  <= 4'd0;
      rw_m_q  <= 1'b0;
      rd_w_q  <= 4'd0;
      rw_w_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      e_q     <= e_d;
      rd_m_q  <= rd_m_d;
      rw_m_q  <= rw_m_d;
      rd_w_q  <= rd_m_q;
      rw_w_q  <= rw_m_q;
      ready_q <= 1'b1;
    end
  end

  assign bus.forwardAE = fwd_a;
  assign bus.forwardBE = fwd_b;
  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_f;
  assign bus.StallE    = busy;
  assign bus.FlushD    = pcsrc;
  assign bus.FlushE    = flush_e;
  assign bus.FlushM    = busy;
  assign bus.BusyE     = busy;

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl (MUL_LAT=3).
// Output vector order: {forwardAE, forwardBE, StallF, StallD, StallE,
//                       FlushD, FlushE, FlushM, BusyE}
module tb_exec_hazard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exec_hazard_ctrl_if bus ();

  exec_hazard_ctrl #(
    .MUL_LAT (3),
    .PC_REG  (4'd15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // A MUL can never resolve a branch; flag it if the stimulus ever does that.
  always @(negedge clk) begin
    if (reset) begin
      assert (!(bus.PCSrcE && bus.BusyE)) else begin
        errors++;
        $error("FAIL pcsrc_with_busy obs=1 exp=0");
      end
    end
  end

  function automatic logic [10:0] outs();
    return {bus.forwardAE, bus.forwardBE, bus.StallF, bus.StallD, bus.StallE,
            bus.FlushD, bus.FlushE, bus.FlushM, bus.BusyE};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs,
                     input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic ua, input logic ub, input logic [3:0] rd,
                     input logic rw, input logic mem, input logic mc,
                     input logic rwe, input logic pcs);
    bus.RA1D        = ra1;
    bus.RA2D        = ra2;
    bus.UseA_D      = ua;
    bus.UseB_D      = ub;
    bus.RdD         = rd;
    bus.RegWriteD   = rw;
    bus.MemtoRegD   = mem;
    bus.MultiCycleD = mc;
    bus.RegWriteE   = rwe;
    bus.PCSrcE      = pcs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    // PCSrcE held high through reset and the first cycle after it
    drv(4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
    tick(); tick(); mid();
    chk("in_reset", outs(), 11'b0);

    tick(); reset = 1'b1; mid();
    chk("first_cycle", outs(), 11'b0);

    // D: ADD R1,R5,R6
    tick(); drv(4'd5, 4'd6, 1, 1, 4'd1, 1, 0, 0, 0, 0); mid();
    chk("idle", outs(), 11'b0);

    // E: ADD R1 | D: SUB R2,R1,R7
    tick(); drv(4'd1, 4'd7, 1, 1, 4'd2, 1, 0, 0, 1, 0); mid();
    chk("add_in_e", outs(), 11'b0);

    // E: SUB(R1,R7) M: ADD R1 | D: ADD R3,R8,R9
    tick(); drv(4'd8, 4'd9, 1, 1, 4'd3, 1, 0, 0, 1, 0); mid();
    chk("b2b", outs(), {2'b10, 2'b00, 7'b0000000});

    // E: ADD R3 | D: ORR R10,R11,R12
    tick(); drv(4'd11, 4'd12, 1, 1, 4'd10, 1, 0, 0, 1, 0); mid();
    chk("add3_in_e", outs(), 11'b0);

    // E: ORR M: ADD R3 | D: SUB R4,R3,R13
    tick(); drv(4'd3, 4'd13, 1, 1, 4'd4, 1, 0, 0, 1, 0);
    // E: SUB(R3,R13) M: ORR R10 W: ADD R3 | D: ADD R15 (no sources)
    tick(); drv(4'd0, 4'd0, 0, 0, 4'd15, 1, 0, 0, 1, 0); mid();
    chk("gap", outs(), {2'b01, 2'b00, 7'b0000000});

    // E: ADD R15 | D: SUB R5,R15,R15
    tick(); drv(4'd15, 4'd15, 1, 1, 4'd5, 1, 0, 0, 1, 0);
    // E: SUB(R15,R15) M: ADD R15 | D: LDR R3,[R6]
    tick(); drv(4'd6, 4'd0, 1, 0, 4'd3, 1, 1, 0, 1, 0); mid();
    chk("pc_nofwd", outs(), 11'b0);

    // E: LDR R3 | D: ADD R4,R3,R7 -> load-use
    tick(); drv(4'd3, 4'd7, 1, 1, 4'd4, 1, 0, 0, 1, 0); mid();
    chk("ldstall", outs(), {2'b00, 2'b00, 7'b1100100});

    // E: bubble M: LDR R3 | D: ADD R4 (held)
    tick(); drv(4'd3, 4'd7, 1, 1, 4'd4, 1, 0, 0, 0, 0); mid();
    chk("ld_release", outs(), 11'b0);

    // E: ADD(R3,R7) M: bubble W: LDR R3 | D: LDR R7,[R2]
    tick(); drv(4'd2, 4'd0, 1, 0, 4'd7, 1, 1, 0, 1, 0); mid();
    chk("ld_fwd", outs(), {2'b01, 2'b00, 7'b0000000});

    // E: LDR R7 | D: ADD R8,R7 (load-use) with taken branch in E
    tick(); drv(4'd7, 4'd0, 1, 0, 4'd8, 1, 0, 0, 1, 1); mid();
    chk("br_over_ld", outs(), {2'b00, 2'b00, 7'b0001100});

    // E: bubble | D: MUL R9,R1,R2
    tick(); drv(4'd1, 4'd2, 1, 1, 4'd9, 1, 0, 1, 0, 0); mid();
    chk("br_bubble", outs(), 11'b0);
    chk("br_rde", {7'b0, dut.e_q.rd}, 11'd0);

    // E: MUL R9 (busy) | D: ADD R10,R9,R1
    tick(); drv(4'd9, 4'd1, 1, 1, 4'd10, 1, 0, 0, 1, 0); mid();
    chk("mul_busy1", outs(), {2'b00, 2'b00, 7'b1110011});
    tick(); mid();
    chk("mul_busy2", outs(), {2'b00, 2'b00, 7'b1110011});
    tick(); mid();
    chk("mul_done", outs(), 11'b0);

    // E: ADD(R9,R1) M: MUL R9 | D: MUL R11,R2,R3
    tick(); drv(4'd2, 4'd3, 1, 1, 4'd11, 1, 0, 1, 1, 0); mid();
    chk("mul_fwd", outs(), {2'b10, 2'b00, 7'b0000000});

    // E: MUL R11 (busy) | D: ADD R12,R11,R2
    tick(); drv(4'd11, 4'd2, 1, 1, 4'd12, 1, 0, 0, 1, 0); mid();
    chk("mul2_busy", outs(), {2'b00, 2'b00, 7'b1110011});

    // asynchronous reset in the middle of the MUL
    #2; reset = 1'b0; #1;
    chk("rst_mid", outs(), 11'b0);
    tick(); reset = 1'b1; mid();
    chk("rst_first", outs(), 11'b0);

    // E: ADD R12(R11,R2) | D: SUB R13,R12
    tick(); drv(4'd12, 4'd0, 1, 0, 4'd13, 1, 0, 0, 1, 0); mid();
    chk("post_rst_add", outs(), 11'b0);

    // E: SUB(R12) M: ADD R12 | D: ADD R1,R2,R3
    tick(); drv(4'd2, 4'd3, 1, 1, 4'd1, 1, 0, 0, 1, 0); mid();
    chk("post_rst_fwd", outs(), {2'b10, 2'b00, 7'b0000000});

    // dual match, both writes enabled
    tick(); drv(4'd4, 4'd5, 1, 1, 4'd1, 1, 0, 0, 1, 0);
    tick(); drv(4'd1, 4'd1, 1, 1, 4'd6, 1, 0, 0, 1, 0);
    tick(); drv(4'd2, 4'd3, 1, 1, 4'd1, 1, 0, 0, 1, 0); mid();
    chk("dual_M", outs(), {2'b10, 2'b10, 7'b0000000});

    // dual match, the younger writer fails its condition
    tick(); drv(4'd4, 4'd5, 1, 1, 4'd1, 1, 0, 0, 1, 0);
    tick(); drv(4'd1, 4'd1, 1, 1, 4'd6, 1, 0, 0, 0, 0);
    tick(); drv(4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0); mid();
    chk("dual_W", outs(), {2'b01, 2'b01, 7'b0000000});

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
